// File: rtl/m68k_bus_sequencer.sv
// 68000 bus cycle sequencer: power-on reset release, region selects, wait-stated DTACK, single-step.
// Define PIXY_BUS_TIMEOUT_EN to build the bus-error timeout for unmapped cycles.
module m68k_bus_sequencer #(
  parameter int unsigned POR_CYCLES   = 10000,
  parameter int unsigned WAIT_ROM     = 2,
  parameter int unsigned WAIT_RAM     = 0,
  parameter int unsigned WAIT_IO      = 4,
`ifdef PIXY_BUS_TIMEOUT_EN
  parameter int unsigned BERR_TIMEOUT = 255,
`endif
  parameter int unsigned DEBOUNCE     = 1000
) (
  input  logic       CPUCLK_IN,
  input  logic       RESET_IN,
  input  logic       STEPEN_IN,
  input  logic       STEP_IN,
  input  logic       AS_IN,
  input  logic       UDS_IN,
  input  logic       LDS_IN,
  input  logic [3:0] ADDR_IN,
  output logic       CPU_RESET_N,
  output logic       CPU_HALT_N,
  output logic       RUN,
  output logic       DTACK_N,
  output logic       BERR_N,
  output logic       ROMSEL,
  output logic       RAMSEL,
  output logic       IOSEL,
  output logic       STEPWAIT
);

  localparam logic [2:0] StPor  = 3'd0;
  localparam logic [2:0] StIdle = 3'd1;
  localparam logic [2:0] StWait = 3'd2;
  localparam logic [2:0] StHold = 3'd3;
  localparam logic [2:0] StAck  = 3'd4;
`ifdef PIXY_BUS_TIMEOUT_EN
  localparam logic [2:0] StBerr = 3'd5;
  localparam logic [7:0] TmoLast = 8'(BERR_TIMEOUT);
`endif

  localparam logic [1:0] RegNone = 2'd0;
  localparam logic [1:0] RegRom  = 2'd1;
  localparam logic [1:0] RegRam  = 2'd2;
  localparam logic [1:0] RegIo   = 2'd3;

  localparam logic [13:0]  PorLast = 14'(POR_CYCLES - 1);
  localparam int unsigned  DbW     = $clog2(DEBOUNCE + 1);
  localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE - 1);

  logic [2:0]     state_q, state_d;
  logic [13:0]    por_cnt_q, por_cnt_d;
  logic [7:0]     wait_cnt_q, wait_cnt_d;
  logic [1:0]     region_q, region_d;
  logic [1:0]     region_dec;
  logic [7:0]     wait_load;
  logic           stb;
`ifdef PIXY_BUS_TIMEOUT_EN
  logic [7:0]     tmo_q, tmo_d;
`endif

  logic           step_s1_q, step_s2_q;
  logic           step_lvl_q, step_lvl_d;
  logic           step_pulse_q, step_pulse_d;
  logic [DbW-1:0] db_cnt_q, db_cnt_d;

  assign stb = ~AS_IN & (~UDS_IN | ~LDS_IN);

  always_comb begin
    if (ADDR_IN == 4'h0)       region_dec = RegRom;
    else if (ADDR_IN <= 4'h7)  region_dec = RegRam;
    else if (ADDR_IN == 4'hF)  region_dec = RegIo;
    else                       region_dec = RegNone;
  end

  always_comb begin
    case (region_dec)
      RegRom:  wait_load = 8'(WAIT_ROM);
      RegRam:  wait_load = 8'(WAIT_RAM);
      RegIo:   wait_load = 8'(WAIT_IO);
      default: wait_load = 8'd0;
    endcase
  end

  // Accept a level change only after the synchronised input differs for DEBOUNCE cycles.
  always_comb begin
    db_cnt_d     = '0;
    step_lvl_d   = step_lvl_q;
    step_pulse_d = 1'b0;
    if (step_s2_q != step_lvl_q) begin
      if (db_cnt_q == DbLast) begin
        step_lvl_d   = step_s2_q;
        step_pulse_d = step_s2_q;
      end else begin
        db_cnt_d = db_cnt_q + DbW'(1);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    por_cnt_d  = por_cnt_q;
    wait_cnt_d = wait_cnt_q;
    region_d   = region_q;
`ifdef PIXY_BUS_TIMEOUT_EN
    tmo_d      = tmo_q;
`endif
    case (state_q)
      StPor: begin
        if (por_cnt_q >= PorLast) state_d = StIdle;
        else                      por_cnt_d = por_cnt_q + 14'd1;
      end
      StIdle: begin
        if (stb) begin
          region_d   = region_dec;
          wait_cnt_d = wait_load;
`ifdef PIXY_BUS_TIMEOUT_EN
          tmo_d      = 8'd0;
`endif
          state_d    = StWait;
        end
      end
      StWait: begin
        // Abort has priority over every exit decision.
        if (AS_IN) begin
          state_d = StIdle;
        end else if (region_q == RegNone) begin
`ifdef PIXY_BUS_TIMEOUT_EN
          if (tmo_q >= TmoLast) state_d = StBerr;
          else                  tmo_d   = tmo_q + 8'd1;
`endif
        end else if (wait_cnt_q == 8'd0) begin
          state_d = STEPEN_IN ? StHold : StAck;
        end else begin
          wait_cnt_d = wait_cnt_q - 8'd1;
        end
      end
      StHold: begin
        if (AS_IN)                             state_d = StIdle;
        else if (step_pulse_q || !STEPEN_IN)   state_d = StAck;
      end
      StAck: begin
        if (AS_IN) state_d = StIdle;
      end
`ifdef PIXY_BUS_TIMEOUT_EN
      StBerr: begin
        if (AS_IN) state_d = StIdle;
      end
`endif
      default: state_d = StPor;
    endcase
  end

  always_ff @(posedge CPUCLK_IN) begin
    if (RESET_IN) begin
      state_q      <= StPor;
      por_cnt_q    <= 14'd0;
      wait_cnt_q   <= 8'd0;
      region_q     <= RegNone;
`ifdef PIXY_BUS_TIMEOUT_EN
      tmo_q        <= 8'd0;
`endif
      step_s1_q    <= 1'b0;
      step_s2_q    <= 1'b0;
      step_lvl_q   <= 1'b0;
      step_pulse_q <= 1'b0;
      db_cnt_q     <= '0;
    end else begin
      state_q      <= state_d;
      por_cnt_q    <= por_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      region_q     <= region_d;
`ifdef PIXY_BUS_TIMEOUT_EN
      tmo_q        <= tmo_d;
`endif
      step_s1_q    <= STEP_IN;
      step_s2_q    <= step_s1_q;
      step_lvl_q   <= step_lvl_d;
      step_pulse_q <= step_pulse_d;
      db_cnt_q     <= db_cnt_d;
    end
  end

  logic sel_active;
  assign sel_active  = (state_q == StWait) || (state_q == StHold) || (state_q == StAck);

  assign CPU_RESET_N = (state_q != StPor);
  assign CPU_HALT_N  = (state_q != StPor);
  assign RUN         = (state_q != StPor);
  assign DTACK_N     = (state_q != StAck);
`ifdef PIXY_BUS_TIMEOUT_EN
  assign BERR_N      = (state_q != StBerr);
`else
  assign BERR_N      = 1'b1;
`endif
  assign ROMSEL      = sel_active && (region_q == RegRom);
  assign RAMSEL      = sel_active && (region_q == RegRam);
  assign IOSEL       = sel_active && (region_q == RegIo);
  assign STEPWAIT    = (state_q == StHold);

endmodule
